tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent tick channels (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, meaning period and counter width.
REQ-003 SHALL have parameter RST_PERIOD, default 50000000, meaning per-channel period loaded at reset.
REQ-004 SHALL have port clk_in  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_valid  input  1  command present.
REQ-007 SHALL have port cfg_ready  output  1  command accepted on a cycle where cfg_valid&&cfg_ready.
REQ-008 SHALL have port cfg_op  input  2  command: 00 SETP, 01 START, 10 STOP, 11 RESTART.
REQ-009 SHALL have port cfg_ch  input  $clog2(NCH)  target channel.
REQ-010 SHALL have port cfg_period  input  WIDTH  new period in clk_in cycles; used by SETP only.
REQ-011 SHALL have port cfg_err  output  1  one-cycle pulse: command rejected.
REQ-012 SHALL have port tick  output  NCH  one-cycle enable pulse per channel.
REQ-013 SHALL have port sq  output  NCH  approximately 50% square wave per channel.
REQ-014 SHALL have port running  output  NCH  channel-active flags.

Function
REQ-015 SHALL implement a command FSM with states IDLE (cfg_ready=1) and APPLY (cfg_ready=0); accept moves IDLE->APPLY, APPLY returns to IDLE unconditionally after one cycle, giving at most one command every 2 cycles.
REQ-016 SHALL register cfg_op/cfg_ch/cfg_period at accept and act on them in APPLY.
REQ-017 SHALL, on SETP, store cfg_period as pending_period[ch]; active period SHALL switch to pending at the channel's next wrap, or immediately if the channel is stopped.
REQ-018 SHALL reject SETP with cfg_period==0: no state change, cfg_err high for the APPLY cycle.
REQ-019 SHALL reject cfg_ch>=NCH (any op) identically to REQ-018.
REQ-020 SHALL, on START of a stopped channel, clear cnt and sq and set running; START of a running channel SHALL be a no-op.
REQ-021 SHALL, on STOP, clear running, cnt and sq; tick SHALL not assert while stopped.
REQ-022 SHALL, on RESTART, load pending period, clear cnt and sq, and set running, regardless of prior state.
REQ-023 SHALL, while running, increment cnt each cycle and wrap to 0 at cnt==period-1; tick[ch] SHALL be high exactly in the cycle cnt==period-1.
REQ-024 SHALL toggle sq[ch] at cnt==period/2 (integer division) and at wrap; for period==1 tick SHALL stay high continuously and sq SHALL hold 0.
REQ-025 SHALL give first tick exactly period cycles after running rises (period==1: the cycle running rises).
REQ-026 SHALL force cnt to 0 if cnt>period-1 (period shrunk by immediate load), without asserting tick that cycle.
REQ-027 SHALL ensure that a command to one channel never perturbs counters of other channels.
REQ-028 SHALL drive tick, sq and running from registers (no combinational path from cfg_* to tick/sq/running).

Reset
REQ-029 SHALL, while rst_ low: FSM=IDLE, cfg_ready=0, cfg_err=0, tick=0, sq=0, running=0, cnt=0, period and pending_period=RST_PERIOD.
REQ-030 SHALL raise cfg_ready the first cycle after rst_ deasserts; reset mid-APPLY SHALL discard the command.

Structure
REQ-031 SHALL take opcode constants (OP_SETP, OP_START, OP_STOP, OP_RESTART) and FSM state encodings from the shared package tick_pkg.
REQ-032 SHALL instantiate NCH copies of one sub-module tick_channel (counter, period/pending registers, tick/sq generation) beneath the command FSM.

Verification
REQ-033 SHALL verify: reset, SETP ch0 period=4, START ch0 -> tick[0] every 4th cycle, first 4 cycles after running[0]; sq[0] toggles at cnt 2 and 0.
REQ-034 SHALL verify: ch0 running period=4, SETP ch0 period=6 mid-count -> remaining ticks at 4-spacing until wrap, then 6-spacing, no double tick.
REQ-035 SHALL verify: SETP period=0 and cfg_ch=NCH -> cfg_err one-cycle pulse each, all outputs unchanged.
REQ-036 SHALL verify: back-to-back cfg_valid held high -> cfg_ready toggles 1,0,1,0; exactly one command per 2 cycles.
REQ-037 SHALL verify: period=1 START -> tick continuously 1, sq 0; STOP -> tick 0 next cycle after APPLY.
REQ-038 SHALL verify: ch1 running period=10, rst_ pulsed low mid-count -> all outputs 0; after release period=RST_PERIOD, running=0.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared definitions for the tick scheduler: command opcodes and the
// command-FSM state encoding.
package tick_pkg;

  typedef enum logic [1:0] {
    OP_SETP    = 2'b00,
    OP_START   = 2'b01,
    OP_STOP    = 2'b10,
    OP_RESTART = 2'b11
  } tick_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } cmd_state_e;

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration command bus of the tick scheduler.
//   cfg_valid  : command present (master -> slave)
//   cfg_ready  : slave can accept a command this cycle
//   cfg_op     : opcode (tick_pkg::tick_op_e encoding)
//   cfg_ch     : target channel
//   cfg_period : new period in clock cycles, SETP only
//   cfg_err    : one-cycle pulse, command rejected
interface tick_scheduler_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_op;
  logic [CW-1:0]    cfg_ch;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_op, cfg_ch, cfg_period,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_ch, cfg_period,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/tick_channel.sv
// One tick channel: free-running counter with active and pending period,
// producing a one-cycle tick at cnt==period-1 and a ~50% square wave.
//   clk_in, rst_ : clock, asynchronous active-low reset
//   cmd_en       : a validated command targets this channel this cycle
//   cmd_op       : opcode of that command
//   cmd_period   : period operand (SETP)
//   tick, sq     : registered tick pulse and square wave
//   running      : channel active
module tick_channel
  import tick_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int unsigned RST_PERIOD = 50000000
) (
  input  logic             clk_in,
  input  logic             rst_,
  input  logic             cmd_en,
  input  tick_op_e         cmd_op,
  input  logic [WIDTH-1:0] cmd_period,
  output logic             tick,
  output logic             sq,
  output logic             running
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] period, period_n;
  logic [WIDTH-1:0] pending, pending_n;
  logic             run_n, tick_n, sq_n;

  always_comb begin
    run_n     = running;
    cnt_n     = cnt;
    period_n  = period;
    pending_n = pending;

    if (running) begin
      if (cnt > period - ONE) begin
        cnt_n = '0;
      end else if (cnt == period - ONE) begin
        cnt_n    = '0;
        period_n = pending;
      end else begin
        cnt_n = cnt + ONE;
      end
    end

    if (cmd_en) begin
      case (cmd_op)
        OP_SETP: begin
          pending_n = cmd_period;
          if (!running) period_n = cmd_period;
        end
        OP_START: begin
          if (!running) begin
            run_n = 1'b1;
            cnt_n = '0;
          end
        end
        OP_STOP: begin
          run_n = 1'b0;
          cnt_n = '0;
        end
        OP_RESTART: begin
          period_n = pending;
          run_n    = 1'b1;
          cnt_n    = '0;
        end
      endcase
    end

    // tick and sq are decoded from the next state and registered, so they
    // line up with the counter value they describe. The level compare
    // against period/2 toggles sq exactly at cnt==period/2 and at the wrap.
    tick_n = run_n && (cnt_n == period_n - ONE);
    sq_n   = run_n && (period_n != ONE) && (cnt_n >= (period_n >> 1));
  end

  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      cnt     <= '0;
      period  <= WIDTH'(RST_PERIOD);
      pending <= WIDTH'(RST_PERIOD);
      running <= 1'b0;
      tick    <= 1'b0;
      sq      <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      period  <= period_n;
      pending <= pending_n;
      running <= run_n;
      tick    <= tick_n;
      sq      <= sq_n;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler. A two-state command FSM accepts at most one
// command every two cycles from the cfg bus, validates it and hands it to
// the addressed tick_channel instance.
//   clk_in, rst_ : clock, asynchronous active-low reset
//   cfg          : command bus (slave side)
//   tick         : per-channel one-cycle tick pulses
//   sq           : per-channel square waves
//   running      : per-channel active flags
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int          NCH        = 4,
  parameter int          WIDTH      = 32,
  parameter int unsigned RST_PERIOD = 50000000
) (
  input  logic              clk_in,
  input  logic              rst_,
  tick_scheduler_if.slave   cfg,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    sq,
  output logic [NCH-1:0]    running
);

  localparam int CW = $clog2(NCH);

  cmd_state_e       state, state_n;
  logic             ready_q, ready_n;
  logic             accept;
  logic             cmd_ok;
  logic             cmd_valid;
  logic             err;
  tick_op_e         op_q;
  logic [CW-1:0]    ch_q;
  logic [WIDTH-1:0] period_q;

  assign accept = cfg.cfg_valid && ready_q;
  assign cmd_ok = (int'(ch_q) < NCH) && !((op_q == OP_SETP) && (period_q == '0));

  always_ff @(posedge clk_in or negedge rst_) begin
    if (!rst_) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b0;
      op_q     <= OP_SETP;
      ch_q     <= '0;
      period_q <= '0;
    end else begin
      state   <= state_n;
      ready_q <= ready_n;
      if (accept) begin
        op_q     <= tick_op_e'(cfg.cfg_op);
        ch_q     <= cfg.cfg_ch;
        period_q <= cfg.cfg_period;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cmd_valid = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_n = ST_APPLY;
      end
      ST_APPLY: begin
        state_n = ST_IDLE;
        if (cmd_ok) cmd_valid = 1'b1;
        else        err       = 1'b1;
      end
    endcase
    // cfg_ready is registered so it stays low throughout reset and rises
    // on the first clock after release.
    ready_n = (state_n == ST_IDLE);
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .WIDTH      (WIDTH),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_       (rst_),
      .cmd_en     (cmd_valid && (ch_q == CW'(g))),
      .cmd_op     (op_q),
      .cmd_period (period_q),
      .tick       (tick[g]),
      .sq         (sq[g]),
      .running    (running[g])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler (NCH=3 so an out-of-range channel
// number is expressible, WIDTH=16, RST_PERIOD=20).
module tb_tick_scheduler;
  import tick_pkg::*;

  localparam int NCH   = 3;
  localparam int WIDTH = 16;
  localparam int RSTP  = 20;

  logic           clk = 1'b0;
  logic           rst_ = 1'b0;
  logic [NCH-1:0] tick, sq, running;
  int             checks = 0;
  int             failures = 0;

  tick_scheduler_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  tick_scheduler #(.NCH(NCH), .WIDTH(WIDTH), .RST_PERIOD(RSTP)) dut (
    .clk_in  (clk),
    .rst_    (rst_),
    .cfg     (bus),
    .tick    (tick),
    .sq      (sq),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cfg_ready, presents one command for one edge and
  // returns in the APPLY cycle with the observed cfg_err.
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch,
                          input logic [WIDTH-1:0] per, output logic e);
    int n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_wait_ready got=%b exp=1", bus.cfg_ready);
    end
    bus.cfg_valid  = 1'b1;
    bus.cfg_op     = op;
    bus.cfg_ch     = ch;
    bus.cfg_period = per;
    step();
    bus.cfg_valid = 1'b0;
    e = bus.cfg_err;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({bus.cfg_ready, bus.cfg_err, tick, sq, running} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {bus.cfg_ready, bus.cfg_err, tick, sq, running});
    end
    @(negedge clk);
    rst_ = 1'b1;
    step();
    checks++;
    if (bus.cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise got=%b exp=1", bus.cfg_ready);
    end
  endtask

  task automatic test_basic_period4();
    logic e;
    send_cmd(OP_SETP, 2'd0, 16'd4, e);
    checks++;
    if ({e, bus.cfg_ready} !== 2'b00) begin
      failures++;
      $display("FAIL setp_apply_err_ready got=%b exp=00", {e, bus.cfg_ready});
    end
    step();
    send_cmd(OP_START, 2'd0, 16'd0, e);
    step();
    for (int c = 0; c < 12; c++) begin
      checks++;
      if ({running[0], sq[0], tick[0]} !== {1'b1, (c % 4) >= 2, (c % 4) == 3}) begin
        failures++;
        $display("FAIL p4_cycle%0d got=%b exp=%b", c, {running[0], sq[0], tick[0]},
                 {1'b1, (c % 4) >= 2, (c % 4) == 3});
      end
      step();
    end
  endtask

  task automatic test_setp_midcount();
    logic e;
    logic exp_t, exp_s;
    send_cmd(OP_RESTART, 2'd0, 16'd0, e);
    step();
    for (int c = 0; c < 26; c++) begin
      if (c < 8) begin
        exp_t = (c % 4) == 3;
        exp_s = (c % 4) >= 2;
      end else begin
        exp_t = ((c - 8) % 6) == 5;
        exp_s = ((c - 8) % 6) >= 3;
      end
      checks++;
      if ({sq[0], tick[0]} !== {exp_s, exp_t}) begin
        failures++;
        $display("FAIL midsetp_cycle%0d got=%b exp=%b", c, {sq[0], tick[0]}, {exp_s, exp_t});
      end
      if (c == 4) begin
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
          failures++;
          $display("FAIL midsetp_ready got=%b exp=1", bus.cfg_ready);
        end
        bus.cfg_valid  = 1'b1;
        bus.cfg_op     = OP_SETP;
        bus.cfg_ch     = 2'd0;
        bus.cfg_period = 16'd6;
      end
      if (c == 5) bus.cfg_valid = 1'b0;
      step();
    end
    checks++;
    if (running !== 3'b001) begin
      failures++;
      $display("FAIL midsetp_other_channels got=%b exp=001", running);
    end
  endtask

  task automatic test_errors();
    logic e;
    send_cmd(OP_STOP, 2'd0, 16'd0, e);
    step();
    checks++;
    if ({running, tick, sq} !== '0) begin
      failures++;
      $display("FAIL stop_outputs got=%b exp=0", {running, tick, sq});
    end
    send_cmd(OP_SETP, 2'd0, 16'd0, e);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("FAIL err_period0_pulse got=%b exp=1", e);
    end
    step();
    checks++;
    if ({bus.cfg_err, running, tick, sq} !== '0) begin
      failures++;
      $display("FAIL err_period0_after got=%b exp=0", {bus.cfg_err, running, tick, sq});
    end
    send_cmd(OP_START, 2'd3, 16'd0, e);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("FAIL err_badch_pulse got=%b exp=1", e);
    end
    step();
    checks++;
    if ({bus.cfg_err, running, tick, sq} !== '0) begin
      failures++;
      $display("FAIL err_badch_after got=%b exp=0", {bus.cfg_err, running, tick, sq});
    end
    send_cmd(OP_START, 2'd0, 16'd0, e);
    step();
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (tick[0] !== ((c % 6) == 5)) begin
        failures++;
        $display("FAIL err_period_kept_cycle%0d got=%b exp=%b", c, tick[0], (c % 6) == 5);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int accepts = 0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_op     = OP_SETP;
    bus.cfg_ch     = 2'd2;
    bus.cfg_period = 16'd7;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus.cfg_ready, bus.cfg_err} !== {(k % 2) == 0, 1'b0}) begin
        failures++;
        $display("FAIL b2b_ready_k%0d got=%b exp=%b", k, {bus.cfg_ready, bus.cfg_err},
                 {(k % 2) == 0, 1'b0});
      end
      if (bus.cfg_valid && bus.cfg_ready) accepts++;
      step();
    end
    bus.cfg_valid = 1'b0;
    checks++;
    if (accepts != 3) begin
      failures++;
      $display("FAIL b2b_accepts got=%0d exp=3", accepts);
    end
    send_cmd(OP_START, 2'd2, 16'd0, e);
    step();
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({running[2], tick[2]} !== {1'b1, c == 6}) begin
        failures++;
        $display("FAIL b2b_p7_cycle%0d got=%b exp=%b", c, {running[2], tick[2]}, {1'b1, c == 6});
      end
      step();
    end
  endtask

  task automatic test_period1();
    logic e;
    send_cmd(OP_SETP, 2'd1, 16'd1, e);
    step();
    send_cmd(OP_START, 2'd1, 16'd0, e);
    step();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({running[1], sq[1], tick[1]} !== 3'b101) begin
        failures++;
        $display("FAIL p1_cycle%0d got=%b exp=101", c, {running[1], sq[1], tick[1]});
      end
      step();
    end
    send_cmd(OP_STOP, 2'd1, 16'd0, e);
    checks++;
    if (tick[1] !== 1'b1) begin
      failures++;
      $display("FAIL p1_stop_apply_tick got=%b exp=1", tick[1]);
    end
    step();
    checks++;
    if ({tick[1], running} !== {1'b0, 3'b101}) begin
      failures++;
      $display("FAIL p1_stop_after got=%b exp=0101", {tick[1], running});
    end
  endtask

  task automatic test_reset_midcount();
    logic e;
    send_cmd(OP_SETP, 2'd1, 16'd10, e);
    step();
    send_cmd(OP_START, 2'd1, 16'd0, e);
    step();
    step();
    step();
    step();
    rst_ = 1'b0;
    #1;
    checks++;
    if ({bus.cfg_ready, bus.cfg_err, tick, sq, running} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=0",
               {bus.cfg_ready, bus.cfg_err, tick, sq, running});
    end
    @(negedge clk);
    rst_ = 1'b1;
    step();
    checks++;
    if ({bus.cfg_ready, running} !== 4'b1000) begin
      failures++;
      $display("FAIL midreset_release got=%b exp=1000", {bus.cfg_ready, running});
    end
    send_cmd(OP_START, 2'd1, 16'd0, e);
    step();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (tick[1] !== (c == RSTP - 1)) begin
        failures++;
        $display("FAIL rst_period_cycle%0d got=%b exp=%b", c, tick[1], c == RSTP - 1);
      end
      step();
    end
    send_cmd(OP_START, 2'd2, 16'd0, e);
    rst_ = 1'b0;
    #2;
    rst_ = 1'b1;
    step();
    checks++;
    if ({bus.cfg_ready, running} !== 4'b1000) begin
      failures++;
      $display("FAIL apply_reset_discard got=%b exp=1000", {bus.cfg_ready, running});
    end
  endtask

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_op     = 2'b00;
    bus.cfg_ch     = '0;
    bus.cfg_period = '0;
    test_reset();
    test_basic_period4();
    test_setp_midcount();
    test_errors();
    test_back_to_back();
    test_period1();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
